// File: rtl/fifo_read_scheduler.sv
// Row-skewed read sequencer for a bank of input-activation FIFOs feeding a systolic array.
// Optional SCHED_AUTO_CLEAR_EN adds a one-cycle CLEAR state that pulses fifo_rclear low after each burst.
module fifo_read_scheduler #(
    parameter int unsigned NUM_FIFOS = 4,
    parameter int unsigned LEN_W     = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    output logic [NUM_FIFOS-1:0] fifo_r_en,
    output logic                 fifo_rclear,
    output logic [NUM_FIFOS-1:0] valid_out,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          stall_cycles
);

    localparam int unsigned T_W  = LEN_W + 5;
    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_RUN   = 3'd1;
    localparam logic [ST_W-1:0] S_DRAIN = 3'd2;
    localparam logic [ST_W-1:0] S_DONE  = 3'd3;
`ifdef SCHED_AUTO_CLEAR_EN
    localparam logic [ST_W-1:0] S_CLEAR = 3'd4;
`endif

    logic [ST_W-1:0]      state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [T_W-1:0]       t_q, t_d;
    logic [15:0]          stall_q, stall_d;
    logic [NUM_FIFOS-1:0] valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rclear_q;

    logic [NUM_FIFOS-1:0] lane_active;
    logic                 stall;
    logic [T_W-1:0]       t_last;

    // Lane i is in its read window once the skew offset has elapsed and until len words are taken.
    always_comb begin
        lane_active = '0;
        for (int i = 0; i < int'(NUM_FIFOS); i++) begin
            lane_active[i] = (t_q >= T_W'(i)) && ((t_q - T_W'(i)) < T_W'(len_q));
        end
    end

    assign stall     = |(lane_active & fifo_empty);
    assign t_last    = T_W'(len_q) + T_W'(NUM_FIFOS - 2);
    assign fifo_r_en = ((state_q == S_RUN) && !stall) ? lane_active : '0;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        t_d     = t_q;
        stall_d = stall_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        len_d   = burst_len;
                        t_d     = '0;
                        stall_d = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // A stall freezes every lane so the row skew is never disturbed.
                if (stall) begin
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end else if (t_q == t_last) begin
                    state_d = S_DRAIN;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
`ifdef SCHED_AUTO_CLEAR_EN
            S_DONE:  state_d = S_CLEAR;
            S_CLEAR: state_d = S_IDLE;
`else
            S_DONE:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            t_q      <= '0;
            stall_q  <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rclear_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            t_q      <= t_d;
            stall_q  <= stall_d;
            valid_q  <= fifo_r_en;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
`ifdef SCHED_AUTO_CLEAR_EN
            rclear_q <= (state_d != S_CLEAR);
`else
            rclear_q <= 1'b1;
`endif
        end
    end

    assign valid_out    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fifo_rclear  = rclear_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed self-checking bench for fifo_read_scheduler (NUM_FIFOS=4, LEN_W=12).
module tb_fifo_read_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] burst_len;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_r_en;
    logic        fifo_rclear;
    logic [3:0]  valid_out;
    logic        busy;
    logic        done;
    logic [15:0] stall_cycles;

`ifdef SCHED_AUTO_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    int n_vec      = 0;
    int n_miscmp   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] emp_q[$];

    fifo_read_scheduler #(.NUM_FIFOS(4), .LEN_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .burst_len    (burst_len),
        .fifo_empty   (fifo_empty),
        .fifo_r_en    (fifo_r_en),
        .fifo_rclear  (fifo_rclear),
        .valid_out    (valid_out),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Launch a burst and check every output cycle by cycle against exp_q/emp_q tables.
    task automatic burst(input string tag, input logic [11:0] len, input int done_cyc,
                         input int exp_stall, input int exp_pulses,
                         input int rs_first, input int rs_last);
        logic [3:0] prev;
        logic [3:0] cur;
        int         pulses;
        int         ncyc;
        prev   = '0;
        pulses = 0;
        ncyc   = done_cyc + 2;
        start      = 1'b1;
        burst_len  = len;
        fifo_empty = '0;
        tick();
        for (int k = 1; k <= ncyc; k++) begin
            fifo_empty = (k <= emp_q.size()) ? emp_q[k-1] : 4'b0000;
            if (k >= rs_first && k <= rs_last) begin
                start     = 1'b1;
                burst_len = 12'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            cur = (k <= exp_q.size()) ? exp_q[k-1] : 4'b0000;
            check({tag, ".r_en"},   32'(fifo_r_en),   32'(cur));
            check({tag, ".valid"},  32'(valid_out),   32'(prev));
            check({tag, ".done"},   32'(done),        32'(k == done_cyc));
            check({tag, ".busy"},   32'(busy),        32'(k <= done_cyc + CLR));
            check({tag, ".rclear"}, 32'(fifo_rclear), 32'(!(CLR == 1 && k == done_cyc + 1)));
            pulses += $countones(fifo_r_en);
            prev = cur;
            tick();
        end
        start = 1'b0;
        check({tag, ".stalls"}, 32'(stall_cycles), 32'(exp_stall));
        check({tag, ".pulses"}, 32'(pulses),       32'(exp_pulses));
    endtask

    initial begin
        int bad_ren;
        int bad_busy;
        int seen_done;
        reset      = 1'b1;
        start      = 1'b0;
        burst_len  = '0;
        fifo_empty = '0;
        tick();
        tick();
        #1;
        check("rst.r_en",   32'(fifo_r_en),    32'd0);
        check("rst.valid",  32'(valid_out),    32'd0);
        check("rst.busy",   32'(busy),         32'd0);
        check("rst.done",   32'(done),         32'd0);
        check("rst.stalls", 32'(stall_cycles), 32'd0);
        check("rst.rclear", 32'(fifo_rclear),  32'd0);
        reset = 1'b0;
        tick();
        #1;
        check("post_rst.rclear", 32'(fifo_rclear), 32'd1);

        // len=3, no stalls: done in cycle 8
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        emp_q = '{};
        burst("b3", 12'd3, 8, 0, 12, 0, -1);

        // zero-length burst: DONE directly
        exp_q = '{};
        emp_q = '{};
        burst("b0", 12'd0, 1, 0, 0, 0, -1);

        // lane 2 empty for two cycles at t=3
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 4'b1110, 4'b1100, 4'b1000};
        emp_q = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        burst("stall", 12'd3, 10, 2, 12, 0, -1);

        // start re-asserted with a different length during RUN is ignored
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        emp_q = '{};
        burst("restart", 12'd3, 8, 0, 12, 2, 3);

        // single-word burst: one diagonal of reads
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        emp_q = '{};
        burst("b1", 12'd1, 6, 0, 4, 0, -1);

        // reset asserted at t=2
        start     = 1'b1;
        burst_len = 12'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1;
        check("mid.r_en_t2", 32'(fifo_r_en), 32'b0111);
        reset = 1'b1;
        tick();
        #1;
        check("mid.r_en",   32'(fifo_r_en),    32'd0);
        check("mid.valid",  32'(valid_out),    32'd0);
        check("mid.busy",   32'(busy),         32'd0);
        check("mid.done",   32'(done),         32'd0);
        check("mid.stalls", 32'(stall_cycles), 32'd0);
        check("mid.rclear", 32'(fifo_rclear),  32'd0);
        reset = 1'b0;
        tick();
        #1;
        check("mid.idle_busy", 32'(busy),      32'd0);
        check("mid.idle_ren",  32'(fifo_r_en), 32'd0);

        // all lanes empty for 70000 cycles: counter saturates
        fifo_empty = 4'b1111;
        start      = 1'b1;
        burst_len  = 12'd1;
        tick();
        start    = 1'b0;
        bad_ren  = 0;
        bad_busy = 0;
        for (int k = 0; k < 70000; k++) begin
            #1;
            if (fifo_r_en != 4'b0000) bad_ren++;
            if (busy != 1'b1) bad_busy++;
            tick();
        end
        #1;
        check("sat.stalls",   32'(stall_cycles), 32'hFFFF);
        check("sat.ren_seen", 32'(bad_ren),      32'd0);
        check("sat.busy_low", 32'(bad_busy),     32'd0);
        fifo_empty = 4'b0000;
        seen_done  = 0;
        for (int k = 0; k < 20 && seen_done == 0; k++) begin
            tick();
            #1;
            if (done) seen_done = 1;
        end
        check("sat.done_after_release", 32'(seen_done),    32'd1);
        check("sat.stalls_hold",        32'(stall_cycles), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/fifo_read_scheduler.md
# fifo_read_scheduler

Sequences reads from a bank of NUM_FIFOS single-word-read FIFOs so their outputs reach a systolic array row-skewed: lane i starts i cycles after lane 0. All lanes advance in lockstep, and any lane going empty stalls the whole bank so the skew is preserved. The block sits between the layer controller (start/done) and the input-activation FIFOs (r_en, empty, rclear) on the read-clock side.

## Interface
- NUM_FIFOS, 4, number of FIFO lanes / array rows (2..16)
- LEN_W, 12, width of burst_len; equals FIFO log depth
- clk  in  1  clock (FIFO read clock)
- reset  in  1  synchronous, active-high
- start  in  1  launch request, sampled only in IDLE
- burst_len  in  LEN_W  words to read from each FIFO; latched on accepted start
- fifo_empty  in  NUM_FIFOS  per-lane FIFO empty flag
- fifo_r_en  out  NUM_FIFOS  per-lane read enable (combinational)
- fifo_rclear  out  1  active-low FIFO read-side clear (registered)
- valid_out  out  NUM_FIFOS  lane data valid at FIFO dataOut (registered)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- stall_cycles  out  16  stalled RUN cycles in the current or last burst

## Operation
- States: IDLE, RUN, DRAIN, DONE, and CLEAR (CLEAR only with the macro).
- IDLE: start=1 with burst_len>0 latches len, clears t and stall_cycles, and moves to RUN. start=1 with burst_len=0 moves directly to DONE with no reads. start is ignored in every other state.
- RUN: t counts 0 to T = len+NUM_FIFOS-2. Width of t is LEN_W+5.
  - lane_active[i] = (t >= i) and (t-i < len).
  - stall = OR over i of (lane_active[i] and fifo_empty[i]).
  - fifo_r_en[i] = lane_active[i] and not stall, in state RUN; 0 otherwise.
  - On a stall: t holds and stall_cycles increments, saturating at 16'hFFFF.
  - On a non-stalled cycle with t==T: move to DRAIN. Otherwise t increments.
- DRAIN: 1 cycle, then DONE.
- DONE: done=1 for 1 cycle, then IDLE (or CLEAR with the macro).
- valid_out[i] is fifo_r_en[i] registered by one cycle, so it aligns with the FIFO's registered dataOut.
- fifo_rclear is 0 while reset is asserted and 1 otherwise, except in CLEAR.
- Reset mid-burst: the next state is IDLE. All outputs take their reset values. Reads that are partially consumed are not replayed.

## Timing
- Reset values: fifo_r_en=0, valid_out=0, busy=0, done=0, stall_cycles=0, fifo_rclear=0.
- Start accepted at edge E0: RUN from E0. fifo_r_en[0]=1 in the first RUN cycle if that FIFO is not empty.
- With no stalls: RUN lasts len+NUM_FIFOS-1 cycles, then 1 DRAIN cycle. done is high in cycle len+NUM_FIFOS+1 after E0.
- Each stall extends RUN by exactly one cycle. No lane reads during a stall cycle.
- fifo_empty is used in the same cycle it is presented; there is no registered lookahead.
- Back-to-back bursts: start sampled in the first IDLE cycle after DONE (or after CLEAR) is accepted.

## Configuration
- SCHED_AUTO_CLEAR_EN defined: DONE goes to CLEAR for exactly one cycle.
  - In CLEAR: fifo_rclear=0, busy=1.
  - CLEAR then goes to IDLE. This rewinds FIFO read pointers after every burst.
- Not defined: there is no CLEAR state. fifo_rclear is low only during reset, and DONE goes directly to IDLE.

## Test plan
- NUM_FIFOS=4, burst_len=3, all FIFOs non-empty, start pulse:
  - fifo_r_en is 0001, 0011, 0111, 1110, 1100, 1000 on consecutive cycles.
  - valid_out shows the same pattern one cycle later.
  - done is high in cycle 8 after E0; stall_cycles=0.
- Same setup, but fifo_empty[2] held high for 2 cycles at t=3 (lane 2 starts at t=2, so it is active at t=3):
  - The pattern freezes for 2 cycles with all r_en=0.
  - done is delayed by 2 cycles; stall_cycles=2; total r_en pulses=12.
- start with burst_len=0: no r_en pulses; done pulses in the cycle after E0.
- start asserted again during RUN: ignored, and the burst completes unchanged. reset asserted at t=2: all outputs take their reset values on the next edge and the state is IDLE.
- SCHED_AUTO_CLEAR_EN defined, burst_len=1: one cycle with fifo_rclear=0 immediately after done, and busy stays 1 through it. Without the macro, fifo_rclear stays 1.
- All FIFOs held empty for 70000 cycles: stall_cycles saturates at 16'hFFFF; busy stays 1; no r_en pulses.
